// File: rtl/decoder_pkg.sv
// Shared widths, types and the one-hot helper for the registered 4-to-16 decoder.
// onehot_ok is only used when DECODER_4X16_ONEHOT_CHK_EN is defined.
package decoder_pkg;

    localparam int unsigned DEC_IN_W    = 4;
    localparam int unsigned DEC_OUT_W   = 16;
    localparam int unsigned DEC_GRP_W   = 2;
    localparam int unsigned DEC_NUM_GRP = 4;

    typedef logic [DEC_IN_W-1:0]  dec_sel_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    // True when exactly one bit is set.
    function automatic logic onehot_ok(input dec_onehot_t v);
        return (v != '0) && ((v & (v - dec_onehot_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/decoder_2x4.sv
// Combinational 2-to-4 one-hot decoder stage with enable; all outputs low when disabled.
module decoder_2x4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_4x16_sync.sv
// Registered 4-to-16 one-hot decoder built from 2-to-4 stages, with optional output inversion.
// Optional one-hot integrity monitor (onehot_err port) enabled by DECODER_4X16_ONEHOT_CHK_EN.
module decoder_4x16_sync
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  dec_sel_t    inputs,
    input  logic        en,
    output dec_onehot_t outputs,
    output logic        valid
`ifdef DECODER_4X16_ONEHOT_CHK_EN
   ,output logic        onehot_err
`endif
);

    logic [DEC_NUM_GRP-1:0] grp_en;
    dec_onehot_t            dec_d;
    dec_onehot_t            dec_q;
    logic                   valid_q;

    decoder_2x4 u_grp (
        .en  (en),
        .sel (inputs[DEC_IN_W-1:DEC_GRP_W]),
        .y   (grp_en)
    );

    for (genvar g = 0; g < DEC_NUM_GRP; g++) begin : g_leaf
        decoder_2x4 u_leaf (
            .en  (grp_en[g]),
            .sel (inputs[DEC_GRP_W-1:0]),
            .y   (dec_d[4*g +: 4])
        );
    end

    // Register holds the active-high decode; polarity is applied only at the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= en;
        end
    end

    assign outputs = OUT_ACTIVE_LOW ? ~dec_q : dec_q;
    assign valid   = valid_q;

`ifdef DECODER_4X16_ONEHOT_CHK_EN
    logic err_d;
    logic err_q;

    always_comb begin
        err_d = 1'b0;
        if (valid_q) begin
            err_d = !onehot_ok(dec_q);
        end else begin
            err_d = (dec_q != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign onehot_err = err_q;
`endif

endmodule

// File: tb/tb_decoder_4x16_sync.sv
// Directed self-checking bench for decoder_4x16_sync; runs an active-high and an
// active-low instance side by side on the same stimulus.
module tb_decoder_4x16_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  inputs = 4'h0;
    logic        en = 1'b0;
    logic [15:0] outputs;
    logic        valid;
    logic [15:0] outputs_n;
    logic        valid_n;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [15:0] EXP_TBL [16] = '{
        16'h0001, 16'h0002, 16'h0004, 16'h0008,
        16'h0010, 16'h0020, 16'h0040, 16'h0080,
        16'h0100, 16'h0200, 16'h0400, 16'h0800,
        16'h1000, 16'h2000, 16'h4000, 16'h8000
    };

    always #5 clk = ~clk;

`ifdef DECODER_4X16_ONEHOT_CHK_EN
    logic onehot_err;
    logic onehot_err_n;
    logic err_seen = 1'b0;

    always @(posedge clk) begin
        if (onehot_err || onehot_err_n) err_seen <= 1'b1;
    end
`endif

    decoder_4x16_sync #(
        .OUT_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inputs     (inputs),
        .en         (en),
        .outputs    (outputs),
        .valid      (valid)
`ifdef DECODER_4X16_ONEHOT_CHK_EN
       ,.onehot_err (onehot_err)
`endif
    );

    decoder_4x16_sync #(
        .OUT_ACTIVE_LOW (1'b1)
    ) dut_n (
        .clk        (clk),
        .rst_n      (rst_n),
        .inputs     (inputs),
        .en         (en),
        .outputs    (outputs_n),
        .valid      (valid_n)
`ifdef DECODER_4X16_ONEHOT_CHK_EN
       ,.onehot_err (onehot_err_n)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, leaving 1 time unit of settling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks both instances against one active-high expectation.
    task automatic check_out(input string tag, input logic [15:0] exp, input logic exp_valid);
        check({tag, "_out"},    outputs,   exp);
        check({tag, "_out_n"},  outputs_n, ~exp);
        check({tag, "_valid"},  {15'd0, valid},   {15'd0, exp_valid});
        check({tag, "_valid_n"}, {15'd0, valid_n}, {15'd0, exp_valid});
    endtask

    initial begin
        // Reset asserted before any clock edge, with live inputs.
        #1;
        inputs = 4'h7;
        en     = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_out("rst_async", 16'h0000, 1'b0);
        tick();
        tick();
        check_out("rst_held", 16'h0000, 1'b0);

        rst_n = 1'b1;
        #1;
        check_out("rst_release_pre_edge", 16'h0000, 1'b0);
        tick();
        check_out("rst_first_decode", 16'h0080, 1'b1);

        // Sweep, each code held two cycles, then wrap to zero.
        for (int i = 0; i < 16; i++) begin
            inputs = 4'(i);
            tick();
            check_out($sformatf("sweep%0d_a", i), EXP_TBL[i], 1'b1);
            tick();
            check_out($sformatf("sweep%0d_b", i), EXP_TBL[i], 1'b1);
        end
        inputs = 4'h0;
        tick();
        check_out("wrap", 16'h0001, 1'b1);

        // Enable gating on code 9.
        inputs = 4'h9;
        en     = 1'b1;
        tick();
        check_out("en_on1", 16'h0200, 1'b1);
        en = 1'b0;
        #1;
        check_out("en_off_pre_edge", 16'h0200, 1'b1);
        tick();
        check_out("en_off", 16'h0000, 1'b0);
        en = 1'b1;
        tick();
        check_out("en_on2", 16'h0200, 1'b1);

        // Back-to-back codes, one per cycle.
        inputs = 4'h3;
        tick();
        check_out("b2b_3", 16'h0008, 1'b1);
        inputs = 4'hC;
        tick();
        check_out("b2b_c", 16'h1000, 1'b1);
        inputs = 4'h0;
        tick();
        check_out("b2b_0", 16'h0001, 1'b1);
        inputs = 4'hF;
        tick();
        check_out("b2b_f", 16'h8000, 1'b1);

        // Half-cycle reset pulse mid-stream.
        inputs = 4'hA;
        tick();
        check_out("mid_pre", 16'h0400, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 16'h0000, 1'b0);
        #4;
        rst_n = 1'b1;
        #1;
        check_out("mid_release_pre_edge", 16'h0000, 1'b0);
        tick();
        check_out("mid_resume", 16'h0400, 1'b1);

`ifdef DECODER_4X16_ONEHOT_CHK_EN
        tick();
        check("onehot_err_never", {15'd0, err_seen}, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
